multilane_deserializer: RTL and testbench

Parametrised serial-to-parallel receiver for the accelerator's off-chip input link. It captures a word striped across `LANES` serial lanes, with frame alignment and selectable bit order. Completed words are buffered in a small first-word-fall-through FIFO and delivered on a valid/ready stream to the input-feature/weight loaders. Everything runs on the single system clock; a per-cycle `bit_en` strobe marks link bit times.

---
 rtl/multilane_deserializer.sv | 138 +++++++++++++
 tb/tb_multilane_deserializer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/multilane_deserializer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | multilane_deserializer: striped serial-to-parallel receiver, FWFT out FIFO |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module multilane_deserializer #(
  parameter int WIDTH      = 32,
  parameter int LANES      = 1,
  parameter int LSB_FIRST  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          bit_en,
  input  logic [LANES-1:0]              serial_data,
  input  logic                          frame_sync,
  output logic [WIDTH-1:0]              m_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fill_level,
  output logic                          busy,
  output logic                          frame_err,
  output logic                          overflow
);

  localparam int BEATS = WIDTH / LANES;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int PW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int AW    = $clog2(FIFO_DEPTH);

  typedef enum logic [0:0] {IDLE = 1'b0, RECV = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [BW-1:0]      beat_cnt_q, beat_cnt_d;
  logic [WIDTH-1:0]   asm_q, asm_d;
  logic               frame_err_q, frame_err_d;
  logic               overflow_q, overflow_d;
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]        count_q, count_d;
  logic [WIDTH-1:0]   mem_q [FIFO_DEPTH];
  logic [WIDTH-1:0]   mem_d [FIFO_DEPTH];

  logic               capture, push, pop, full, push_ok;
  logic [BW-1:0]      cur_beat;
  logic [PW-1:0]      pos;

  // Frame assembly: a frame_sync strobe always restarts at beat 0, in either state.
  always_comb begin
    state_d     = state_q;
    beat_cnt_d  = beat_cnt_q;
    asm_d       = asm_q;
    frame_err_d = 1'b0;
    capture     = 1'b0;
    push        = 1'b0;
    cur_beat    = '0;
    pos         = '0;
    if (bit_en) begin
      if (frame_sync) begin
        capture     = 1'b1;
        asm_d       = '0;
        frame_err_d = (state_q == RECV);
      end else if (state_q == RECV) begin
        capture  = 1'b1;
        cur_beat = beat_cnt_q;
      end
    end
    if (capture) begin
      for (int l = 0; l < LANES; l++) begin
        pos = PW'(int'(cur_beat) * LANES + l);
        if (LSB_FIRST == 0) pos = PW'(WIDTH - 1) - pos;
        asm_d[pos] = serial_data[l];
      end
      if (int'(cur_beat) == BEATS - 1) begin
        push       = 1'b1;
        state_d    = IDLE;
        beat_cnt_d = '0;
      end else begin
        state_d    = RECV;
        beat_cnt_d = cur_beat + BW'(1);
      end
    end
  end

  // A full FIFO still accepts the push when the head leaves on the same edge.
  always_comb begin
    pop        = (count_q != '0) && m_ready;
    full       = (count_q == (AW+1)'(FIFO_DEPTH));
    push_ok    = push && (!full || pop);
    overflow_d = overflow_q || (push && full && !pop);
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = asm_d;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      beat_cnt_q  <= '0;
      asm_q       <= '0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      mem_q       <= '{default: '0};
    end else begin
      state_q     <= state_d;
      beat_cnt_q  <= beat_cnt_d;
      asm_q       <= asm_d;
      frame_err_q <= frame_err_d;
      overflow_q  <= overflow_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      mem_q       <= mem_d;
    end
  end

  assign m_data     = mem_q[rd_ptr_q];
  assign m_valid    = (count_q != '0);
  assign fill_level = count_q;
  assign busy       = (state_q == RECV);
  assign frame_err  = frame_err_q;
  assign overflow   = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_multilane_deserializer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_multilane_deserializer: directed bench, 32x1 LSB-first and 32x4 MSB-first|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_multilane_deserializer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        bit_en_a = 1'b0, sync_a = 1'b0, ready_a = 1'b0;
  logic [0:0]  sd_a = '0;
  logic [31:0] data_a;
  logic        valid_a, busy_a, ferr_a, ovf_a;
  logic [2:0]  fill_a;

  logic        bit_en_b = 1'b0, sync_b = 1'b0, ready_b = 1'b1;
  logic [3:0]  sd_b = '0;
  logic [31:0] data_b;
  logic        valid_b, busy_b, ferr_b, ovf_b;
  logic [2:0]  fill_b;

  int checks   = 0;
  int failures = 0;
  int fe_cnt_a = 0;
  int fe_cnt_b = 0;
  int fe_base;
  logic [31:0] wb;

  multilane_deserializer #(.WIDTH(32), .LANES(1), .LSB_FIRST(1), .FIFO_DEPTH(4)) dut_a (
    .clk(clk), .rst(rst), .bit_en(bit_en_a), .serial_data(sd_a), .frame_sync(sync_a),
    .m_data(data_a), .m_valid(valid_a), .m_ready(ready_a), .fill_level(fill_a),
    .busy(busy_a), .frame_err(ferr_a), .overflow(ovf_a));

  multilane_deserializer #(.WIDTH(32), .LANES(4), .LSB_FIRST(0), .FIFO_DEPTH(4)) dut_b (
    .clk(clk), .rst(rst), .bit_en(bit_en_b), .serial_data(sd_b), .frame_sync(sync_b),
    .m_data(data_b), .m_valid(valid_b), .m_ready(ready_b), .fill_level(fill_b),
    .busy(busy_b), .frame_err(ferr_b), .overflow(ovf_b));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ferr_a) fe_cnt_a <= fe_cnt_a + 1;
    if (ferr_b) fe_cnt_b <= fe_cnt_b + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drives beats first..last of word w on instance A, one beat per clock.
  task automatic send_a(input logic [31:0] w, input int first, input int last);
    for (int k = first; k <= last; k++) begin
      bit_en_a = 1'b1;
      sync_a   = (k == 0);
      sd_a[0]  = w[k];
      tick();
    end
    bit_en_a = 1'b0;
    sync_a   = 1'b0;
  endtask

  initial begin
    tick();
    tick();
    rst = 1'b0;
    chk("rst_m_data",   data_a, 32'h0);
    chk("rst_m_valid",  {31'b0, valid_a}, 32'h0);
    chk("rst_fill",     {29'b0, fill_a}, 32'h0);
    chk("rst_busy",     {31'b0, busy_a}, 32'h0);
    chk("rst_frame_err",{31'b0, ferr_a}, 32'h0);
    chk("rst_overflow", {31'b0, ovf_a}, 32'h0);

    // Single LSB-first word with a ready consumer.
    ready_a = 1'b1;
    send_a(32'hA5C3_0F81, 0, 0);
    chk("t1_busy_after_beat0", {31'b0, busy_a}, 32'h1);
    send_a(32'hA5C3_0F81, 1, 31);
    chk("t1_valid", {31'b0, valid_a}, 32'h1);
    chk("t1_data",  data_a, 32'hA5C3_0F81);
    chk("t1_fill",  {29'b0, fill_a}, 32'h1);
    chk("t1_busy_done", {31'b0, busy_a}, 32'h0);
    tick();
    chk("t1_fill_drained", {29'b0, fill_a}, 32'h0);
    chk("t1_valid_drained", {31'b0, valid_a}, 32'h0);

    // Four lanes, MSB-first, bit_en every other cycle.
    wb = 32'h1234_5678;
    for (int k = 0; k < 8; k++) begin
      bit_en_b = 1'b1;
      sync_b   = (k == 0);
      for (int l = 0; l < 4; l++) sd_b[l] = wb[31 - 4*k - l];
      tick();
      bit_en_b = 1'b0;
      sync_b   = 1'b0;
      if (k == 0) chk("t2_busy", {31'b0, busy_b}, 32'h1);
      if (k == 7) begin
        chk("t2_valid", {31'b0, valid_b}, 32'h1);
        chk("t2_data",  data_b, 32'h1234_5678);
      end
      tick();
    end
    chk("t2_no_frame_err", fe_cnt_b, 32'd0);
    chk("t2_fill_drained", {29'b0, fill_b}, 32'h0);

    // Abort a partial frame with an early frame_sync.
    ready_a = 1'b0;
    fe_base = fe_cnt_a;
    send_a(32'h1111_1111, 0, 9);
    send_a(32'hDEAD_BEEF, 0, 0);
    chk("t3_frame_err_pulse", {31'b0, ferr_a}, 32'h1);
    chk("t3_busy", {31'b0, busy_a}, 32'h1);
    send_a(32'hDEAD_BEEF, 1, 1);
    chk("t3_frame_err_clear", {31'b0, ferr_a}, 32'h0);
    send_a(32'hDEAD_BEEF, 2, 31);
    chk("t3_valid", {31'b0, valid_a}, 32'h1);
    chk("t3_data",  data_a, 32'hDEAD_BEEF);
    chk("t3_fill",  {29'b0, fill_a}, 32'h1);
    chk("t3_err_count", fe_cnt_a - fe_base, 32'd1);
    ready_a = 1'b1;
    tick();
    ready_a = 1'b0;
    chk("t3_only_one_word", {29'b0, fill_a}, 32'h0);

    // Five back-to-back frames into a depth-4 FIFO with no consumer.
    for (int i = 1; i <= 5; i++) send_a(i, 0, 31);
    chk("t4_fill_full", {29'b0, fill_a}, 32'h4);
    chk("t4_overflow",  {31'b0, ovf_a}, 32'h1);
    ready_a = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk("t4_drain_data", data_a, i);
      tick();
    end
    ready_a = 1'b0;
    chk("t4_drained_valid", {31'b0, valid_a}, 32'h0);
    chk("t4_overflow_sticky", {31'b0, ovf_a}, 32'h1);

    // Full FIFO with a pop on the edge the fifth word completes.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_overflow_reset", {31'b0, ovf_a}, 32'h0);
    for (int i = 10; i <= 13; i++) send_a(i, 0, 31);
    chk("t5_fill_full", {29'b0, fill_a}, 32'h4);
    send_a(32'd14, 0, 30);
    ready_a = 1'b1;
    send_a(32'd14, 31, 31);
    ready_a = 1'b0;
    chk("t5_fill_stays", {29'b0, fill_a}, 32'h4);
    chk("t5_no_overflow", {31'b0, ovf_a}, 32'h0);
    chk("t5_head", data_a, 32'd11);
    ready_a = 1'b1;
    tick();
    tick();
    ready_a = 1'b0;
    chk("t5_fill_two", {29'b0, fill_a}, 32'h2);
    chk("t5_head_after", data_a, 32'd13);

    // Reset at beat 16 with two words buffered.
    send_a(32'hFFFF_FFFF, 0, 15);
    bit_en_a = 1'b1;
    sd_a[0]  = 1'b1;
    rst      = 1'b1;
    tick();
    rst      = 1'b0;
    bit_en_a = 1'b0;
    chk("t6_m_data",   data_a, 32'h0);
    chk("t6_m_valid",  {31'b0, valid_a}, 32'h0);
    chk("t6_fill",     {29'b0, fill_a}, 32'h0);
    chk("t6_busy",     {31'b0, busy_a}, 32'h0);
    chk("t6_frame_err",{31'b0, ferr_a}, 32'h0);
    chk("t6_overflow", {31'b0, ovf_a}, 32'h0);
    ready_a = 1'b1;
    send_a(32'h0000_0001, 0, 31);
    chk("t6_clean_valid", {31'b0, valid_a}, 32'h1);
    chk("t6_clean_data",  data_a, 32'h0000_0001);
    tick();
    chk("t6_clean_drained", {29'b0, fill_a}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
